// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch, load/store) arbiter onto a single Avalon-MM style port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate winners on ties instead of fixed data-first priority.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifetch_req_i,
    input  logic [31:0] ifetch_addr_i,
    output logic        ifetch_grant_o,
    output logic        ifetch_rvalid_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_byte_en_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_grant_o,
    output logic        data_rvalid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [3:0]  avm_byteenable_o,
    output logic [31:0] avm_writedata_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i
);

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    typedef enum logic {OWNER_FETCH = 1'b0, OWNER_DATA = 1'b1} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, winner;
    logic        we_q;
    logic [31:2] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        cmd_accept;
    logic        any_req;

    assign any_req = ifetch_req_i | data_req_i;
    assign rdata_o = avm_readdata_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_q;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = OWNER_FETCH;
        if (ifetch_req_i && data_req_i)
            winner = (last_q == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
        else if (data_req_i)
            winner = OWNER_DATA;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_q <= OWNER_DATA;
        else if (cmd_accept)
            last_q <= owner_q;
    end
`else
    always_comb begin
        winner = data_req_i ? OWNER_DATA : OWNER_FETCH;
    end
`endif

    // Command fields are captured once in IDLE so they stay stable through any bus stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                owner_q <= winner;
                if (winner == OWNER_DATA) begin
                    we_q    <= data_we_i;
                    addr_q  <= data_addr_i[31:2];
                    be_q    <= data_byte_en_i;
                    wdata_q <= data_wdata_i;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= ifetch_addr_i[31:2];
                    be_q    <= 4'b1111;
                    wdata_q <= '0;
                end
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cmd_accept       = 1'b0;
        avm_read_o       = 1'b0;
        avm_write_o      = 1'b0;
        avm_address_o    = '0;
        avm_byteenable_o = 4'b0000;
        avm_writedata_o  = '0;
        ifetch_rvalid_o  = 1'b0;
        data_rvalid_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = CMD;
            end
            CMD: begin
                avm_read_o       = ~we_q;
                avm_write_o      = we_q;
                avm_address_o    = {addr_q, 2'b00};
                avm_byteenable_o = be_q;
                avm_writedata_o  = wdata_q;
                if (!avm_waitrequest_i) begin
                    cmd_accept = 1'b1;
                    state_d    = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                ifetch_rvalid_o = (owner_q == OWNER_FETCH);
                data_rvalid_o   = (owner_q == OWNER_DATA);
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ifetch_grant_o = cmd_accept && (owner_q == OWNER_FETCH);
    assign data_grant_o   = cmd_accept && (owner_q == OWNER_DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level schedule computed up front.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ifetch_grant, ifetch_rvalid;
    logic        data_req, data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_grant, data_rvalid;
    logic [31:0] rdata;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [3:0]  avm_be;
    logic [31:0] avm_wdata;
    logic        avm_wait;
    logic [31:0] avm_rdata;

    int compared   = 0;
    int mismatched = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ifetch_req_i(ifetch_req), .ifetch_addr_i(ifetch_addr),
        .ifetch_grant_o(ifetch_grant), .ifetch_rvalid_o(ifetch_rvalid),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_byte_en_i(data_be), .data_wdata_i(data_wdata),
        .data_grant_o(data_grant), .data_rvalid_o(data_rvalid),
        .rdata_o(rdata),
        .avm_address_o(avm_address), .avm_read_o(avm_read), .avm_write_o(avm_write),
        .avm_byteenable_o(avm_be), .avm_writedata_o(avm_wdata),
        .avm_waitrequest_i(avm_wait), .avm_readdata_i(avm_rdata)
    );

    always #5 clk = ~clk;

    // Bit order: fetch grant, fetch rvalid, data grant, data rvalid, read, write.
    function automatic logic [5:0] pulses();
        return {ifetch_grant, ifetch_rvalid, data_grant, data_rvalid, avm_read, avm_write};
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifetch_req = 1'b0; ifetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_be = '0; data_wdata = '0;
        avm_wait = 1'b0; avm_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) advance();
        reset = 1'b0;
    endtask

    // Returns 0 for fetch, 1 for data, -1 if no grant within the budget; stops at the grant's negedge.
    task automatic wait_grant(output int who);
        who = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifetch_grant || data_grant) begin
                who = data_grant ? 1 : 0;
                return;
            end
            advance();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        ifetch_req = 1'b1; ifetch_addr = 32'h0000_0010;
        avm_rdata = 32'hA5A5_5A5A;
        repeat (2) advance();
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b0) begin
            mismatched++; $display("[TB] FAIL reset_pulses: got %b expected %b", pulses(), 6'b0);
        end
        compared++;
        if (avm_address !== 32'h0 || avm_be !== 4'h0 || avm_wdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_bus: got addr %h be %h wdata %h expected all 0", avm_address, avm_be, avm_wdata);
        end
        compared++;
        if (rdata !== 32'hA5A5_5A5A) begin
            mismatched++; $display("[TB] FAIL reset_rdata_passthru: got %h expected %h", rdata, 32'hA5A5_5A5A);
        end
        advance();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_fetch_read();
        apply_reset();
        ifetch_req = 1'b1; ifetch_addr = 32'hBFC0_0003; avm_rdata = 32'h1234_5678;
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b0) begin
            mismatched++; $display("[TB] FAIL fetch_idle: got %b expected %b", pulses(), 6'b0);
        end
        advance();
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b100010) begin
            mismatched++; $display("[TB] FAIL fetch_cmd: got %b expected %b", pulses(), 6'b100010);
        end
        compared++;
        if (avm_address !== 32'hBFC0_0000 || avm_be !== 4'b1111) begin
            mismatched++;
            $display("[TB] FAIL fetch_addr_be: got %h/%b expected %h/%b", avm_address, avm_be, 32'hBFC0_0000, 4'b1111);
        end
        advance();
        ifetch_req = 1'b0; ifetch_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b010000 || rdata !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL fetch_rvalid: got %b/%h expected %b/%h", pulses(), rdata, 6'b010000, 32'h1234_5678);
        end
        advance();
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b0) begin
            mismatched++; $display("[TB] FAIL fetch_after: got %b expected %b", pulses(), 6'b0);
        end
        advance();
    endtask

    task automatic test_write_wait();
        apply_reset();
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0100;
        data_be = 4'b0011; data_wdata = 32'hDEAD_BEEF; avm_wait = 1'b1;
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b0) begin
            mismatched++; $display("[TB] FAIL write_idle: got %b expected %b", pulses(), 6'b0);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            logic [5:0] exp_p;
            avm_wait = (k < 3);
            exp_p = (k == 3) ? 6'b001001 : 6'b000001;
            @(negedge clk);
            compared++;
            if (pulses() !== exp_p || avm_address !== 32'h100 || avm_be !== 4'b0011 || avm_wdata !== 32'hDEAD_BEEF) begin
                mismatched++;
                $display("[TB] FAIL write_wait_cycle%0d: got %b %h %b %h expected %b %h %b %h",
                         k, pulses(), avm_address, avm_be, avm_wdata, exp_p, 32'h100, 4'b0011, 32'hDEAD_BEEF);
            end
            advance();
        end
        data_req = 1'b0;
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b0) begin
            mismatched++; $display("[TB] FAIL write_no_rvalid: got %b expected %b", pulses(), 6'b0);
        end
        advance();
    endtask

    task automatic test_reset_mid_cmd();
        apply_reset();
        ifetch_req = 1'b1; ifetch_addr = 32'h0000_0040; avm_wait = 1'b1;
        advance();
        @(negedge clk);
        compared++;
        if (pulses() !== 6'b000010) begin
            mismatched++; $display("[TB] FAIL midcmd_in_cmd: got %b expected %b", pulses(), 6'b000010);
        end
        reset = 1'b1;
        advance();
        reset = 1'b0; ifetch_req = 1'b0; avm_wait = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compared++;
            if (pulses() !== 6'b0 || avm_address !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL midcmd_abandon%0d: got %b/%h expected %b/%h", k, pulses(), avm_address, 6'b0, 32'h0);
            end
            advance();
        end
    endtask

    task automatic test_data_drop();
        int ng, nr, rv_at;
        logic [31:0] rd_exp;
        apply_reset();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_2004; data_be = 4'b1111; avm_wait = 1'b1;
        advance();
        data_req = 1'b0; data_addr = $urandom;
        ng = 0; nr = 0; rv_at = -1;
        for (int k = 0; k < 6; k++) begin
            avm_wait = (k < 2);
            avm_rdata = $urandom;
            rd_exp = avm_rdata;
            @(negedge clk);
            if (k == 0) begin
                compared++;
                if (avm_read !== 1'b1 || avm_address !== 32'h0000_2004) begin
                    mismatched++;
                    $display("[TB] FAIL drop_cmd: got read %b addr %h expected 1 %h", avm_read, avm_address, 32'h2004);
                end
            end
            if (data_grant) ng++;
            if (data_rvalid) begin
                nr++; rv_at = k;
                compared++;
                if (rdata !== rd_exp) begin
                    mismatched++; $display("[TB] FAIL drop_rdata: got %h expected %h", rdata, rd_exp);
                end
            end
            advance();
        end
        compared++;
        if (ng !== 1 || nr !== 1 || rv_at !== 3) begin
            mismatched++;
            $display("[TB] FAIL drop_counts: got grants %0d rvalids %0d at %0d expected 1 1 3", ng, nr, rv_at);
        end
    endtask

    task automatic test_tie();
        int who;
        apply_reset();
        data_we = 1'b1; data_addr = 32'h0000_0300; data_be = 4'b1111; data_wdata = 32'h0BAD_F00D;
        ifetch_addr = 32'h0000_0400;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int r = 0; r < 3; r++) begin
            int exp_who;
            exp_who = (r == 1) ? 1 : 0;
            ifetch_req = 1'b1; data_req = 1'b1;
            wait_grant(who);
            compared++;
            if (who !== exp_who) begin
                mismatched++; $display("[TB] FAIL tie_rr_round%0d: got %0d expected %0d", r, who, exp_who);
            end
            advance();
            ifetch_req = 1'b0; data_req = 1'b0;
            repeat (3) advance();
        end
`else
        ifetch_req = 1'b1; data_req = 1'b1;
        wait_grant(who);
        compared++;
        if (who !== 1) begin
            mismatched++; $display("[TB] FAIL tie_first: got %0d expected %0d", who, 1);
        end
        advance();
        data_req = 1'b0;
        wait_grant(who);
        compared++;
        if (who !== 0) begin
            mismatched++; $display("[TB] FAIL tie_second: got %0d expected %0d", who, 0);
        end
        advance();
        ifetch_req = 1'b0;
        repeat (3) advance();
`endif
    endtask

    localparam int CYC = 700;
    localparam int NT  = 25;

    logic        t_we    [2][NT];
    logic [31:0] t_addr  [2][NT];
    logic [3:0]  t_be    [2][NT];
    logic [31:0] t_wdata [2][NT];
    int          t_gap   [2][NT];
    int          t_rel   [2][NT];
    int          t_gnt   [2][NT];
    int          n_sched [2];
    logic        wait_a  [CYC];
    logic [31:0] rd_a    [CYC];
    logic [5:0]  e_pulse [CYC];
    logic        e_cmd   [CYC];
    logic [31:0] e_addr  [CYC];
    logic [3:0]  e_be    [CYC];
    logic [31:0] e_wdata [CYC];

    // Transaction-level schedule: each pending request waits for the bus to be free,
    // takes one arbitration cycle, then holds the command until the first stall-free cycle.
    task automatic build_schedule();
        int idx [2];
        int rel [2];
        int free_at, last;
        for (int c = 0; c < CYC; c++) begin
            wait_a[c] = (c < CYC - 60) && ($urandom_range(0, 9) < 3);
            rd_a[c] = $urandom;
            e_pulse[c] = '0; e_cmd[c] = 1'b0;
            e_addr[c] = '0; e_be[c] = '0; e_wdata[c] = '0;
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NT; i++) begin
                t_we[r][i]    = (r == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                t_addr[r][i]  = $urandom;
                t_be[r][i]    = (r == 1) ? 4'($urandom_range(1, 15)) : 4'b1111;
                t_wdata[r][i] = (r == 1) ? $urandom : 32'h0;
                t_gap[r][i]   = $urandom_range(0, 4);
                t_rel[r][i]   = 1 << 30;
                t_gnt[r][i]   = -1;
            end
            idx[r] = 0;
            rel[r] = t_gap[r][0];
            n_sched[r] = 0;
        end
        free_at = 0;
        last = 1;
        while (idx[0] < NT || idx[1] < NT) begin
            int pend [2];
            int t, win, g, i;
            for (int r = 0; r < 2; r++) pend[r] = (idx[r] < NT) ? rel[r] : (1 << 30);
            t = (pend[0] < pend[1]) ? pend[0] : pend[1];
            if (t < free_at) t = free_at;
            if (t + 1 >= CYC - 60) break;
            if (pend[0] <= t && pend[1] <= t) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = (last == 1) ? 0 : 1;
`else
                win = 1;
`endif
            end else begin
                win = (pend[1] <= t) ? 1 : 0;
            end
            g = t + 1;
            while (g < CYC - 2 && wait_a[g]) g++;
            i = idx[win];
            t_rel[win][i] = rel[win];
            t_gnt[win][i] = g;
            for (int c = t + 1; c <= g; c++) begin
                e_cmd[c]   = 1'b1;
                e_pulse[c] = {4'b0000, ~t_we[win][i], t_we[win][i]};
                e_addr[c]  = {t_addr[win][i][31:2], 2'b00};
                e_be[c]    = t_be[win][i];
                e_wdata[c] = t_wdata[win][i];
            end
            e_pulse[g] = e_pulse[g] | ((win == 0) ? 6'b100000 : 6'b001000);
            if (!t_we[win][i]) begin
                e_pulse[g + 1] = (win == 0) ? 6'b010000 : 6'b000100;
                free_at = g + 2;
            end else begin
                free_at = g + 1;
            end
            idx[win]++;
            n_sched[win] = idx[win];
            if (idx[win] < NT) rel[win] = g + 1 + t_gap[win][idx[win]];
            last = win;
        end
    endtask

    task automatic test_random();
        int ptr [2];
        build_schedule();
        apply_reset();
        ptr[0] = 0; ptr[1] = 0;
        for (int c = 0; c < CYC; c++) begin
            logic act [2];
            for (int r = 0; r < 2; r++) begin
                while (ptr[r] < n_sched[r] && t_gnt[r][ptr[r]] < c) ptr[r]++;
                act[r] = (ptr[r] < n_sched[r]) && (t_rel[r][ptr[r]] <= c);
            end
            ifetch_req  = act[0];
            ifetch_addr = act[0] ? t_addr[0][ptr[0]] : $urandom;
            data_req    = act[1];
            data_we     = act[1] ? t_we[1][ptr[1]] : 1'($urandom_range(0, 1));
            data_addr   = act[1] ? t_addr[1][ptr[1]] : $urandom;
            data_be     = act[1] ? t_be[1][ptr[1]] : 4'($urandom);
            data_wdata  = act[1] ? t_wdata[1][ptr[1]] : $urandom;
            avm_wait    = wait_a[c];
            avm_rdata   = rd_a[c];
            @(negedge clk);
            compared++;
            if (pulses() !== e_pulse[c]) begin
                mismatched++; $display("[TB] FAIL rand_pulses@%0d: got %b expected %b", c, pulses(), e_pulse[c]);
            end
            if (e_cmd[c]) begin
                compared++;
                if (avm_address !== e_addr[c] || avm_be !== e_be[c] || (avm_write && avm_wdata !== e_wdata[c])) begin
                    mismatched++;
                    $display("[TB] FAIL rand_cmd@%0d: got %h %b %h expected %h %b %h",
                             c, avm_address, avm_be, avm_wdata, e_addr[c], e_be[c], e_wdata[c]);
                end
            end
            if (e_pulse[c][4] || e_pulse[c][2]) begin
                compared++;
                if (rdata !== rd_a[c]) begin
                    mismatched++; $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", c, rdata, rd_a[c]);
                end
            end
            advance();
        end
        compared++;
        if (n_sched[0] + n_sched[1] < 10) begin
            mismatched++; $display("[TB] FAIL rand_scheduled: got %0d expected at least 10", n_sched[0] + n_sched[1]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_read();
        test_write_wait();
        test_reset_mid_cmd();
        test_data_drop();
        test_tie();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
